// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer for the 16-bit pipelined CPU.
// Drives the data-memory handshake for loads/stores, stalls the upstream
// pipeline while an access is in flight and produces the MEM/WB triple.
// Optional feature macro: MEM_TIMEOUT_EN (abort an access after TIMEOUT
// ACCESS cycles without mem_ready and raise the sticky mem_error flag).
module mem_stage_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] result_in,
    input  logic [ADDR_W-1:0] reg_addr_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic              write_enable_in,
    input  logic              store_enable_in,
    input  logic              load_enable_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_reg_addr,
    output logic              wb_write_enable,
    output logic              mem_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] lat_reg_addr;
    logic              mem_op_c;
    logic              expire_c;

    assign mem_op_c = load_enable_in | store_enable_in;

    // Hold IF..EX/MEM while an op waits in IDLE or the access is in flight.
    assign stall = ((state == IDLE) && mem_op_c) || (state == ACCESS);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             mem_error_q;

    // Expiry fires on the TIMEOUT-th ACCESS cycle; mem_ready in that cycle wins.
    assign expire_c  = (state == ACCESS) && !mem_ready &&
                       (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign mem_error = mem_error_q;

    // Wait-cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt     <= '0;
            mem_error_q <= 1'b0;
        end else begin
            if ((state == IDLE) && mem_op_c) begin
                tmo_cnt <= '0;
            end else if ((state == ACCESS) && !mem_ready) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (expire_c) begin
                mem_error_q <= 1'b1;
            end
        end
    end
`else
    assign expire_c  = 1'b0;
    assign mem_error = 1'b0;
`endif

    // Sequencer: state, memory handshake and write-back registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            lat_reg_addr    <= '0;
            wb_data         <= '0;
            wb_reg_addr     <= '0;
            wb_write_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op_c) begin
                        // Load wins when both enables are set.
                        mem_addr        <= mem_addr_in;
                        mem_wdata       <= result_in;
                        lat_reg_addr    <= reg_addr_in;
                        mem_we          <= ~load_enable_in;
                        mem_req         <= 1'b1;
                        wb_write_enable <= 1'b0;
                        state           <= ACCESS;
                    end else begin
                        wb_data         <= result_in;
                        wb_reg_addr     <= reg_addr_in;
                        wb_write_enable <= write_enable_in;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        if (!mem_we) begin
                            wb_data         <= mem_rdata;
                            wb_reg_addr     <= lat_reg_addr;
                            wb_write_enable <= 1'b1;
                        end else begin
                            wb_write_enable <= 1'b0;
                        end
                    end else if (expire_c) begin
                        mem_req         <= 1'b0;
                        wb_write_enable <= 1'b0;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    wb_write_enable <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    mem_req         <= 1'b0;
                    wb_write_enable <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl. Inputs change 1 time unit after
// the rising edge, outputs are sampled on the falling edge.
module tb_mem_stage_ctrl;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] result_in;
    logic [ADDR_W-1:0] reg_addr_in;
    logic [ADDR_W-1:0] mem_addr_in;
    logic              write_enable_in;
    logic              store_enable_in;
    logic              load_enable_in;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] wb_reg_addr;
    logic              wb_write_enable;
    logic              mem_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .result_in      (result_in),
        .reg_addr_in    (reg_addr_in),
        .mem_addr_in    (mem_addr_in),
        .write_enable_in(write_enable_in),
        .store_enable_in(store_enable_in),
        .load_enable_in (load_enable_in),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .stall          (stall),
        .wb_data        (wb_data),
        .wb_reg_addr    (wb_reg_addr),
        .wb_write_enable(wb_write_enable),
        .mem_error      (mem_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic we,
                         input logic [ADDR_W-1:0] maddr, input logic [ADDR_W-1:0] raddr,
                         input logic [DATA_W-1:0] data);
        load_enable_in  = ld;
        store_enable_in = st;
        write_enable_in = we;
        mem_addr_in     = maddr;
        reg_addr_in     = raddr;
        result_in       = data;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0000);
        next_cycle();
        next_cycle();

        // Reset state
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_wb_data", 32'(wb_data), 32'd0);
        check("rst_wb_reg", 32'(wb_reg_addr), 32'd0);
        check("rst_wb_we", 32'(wb_write_enable), 32'd0);
        check("rst_err", 32'(mem_error), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        next_cycle();

        // Non-memory pass-through
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 16'h1234);
        @(negedge clk);
        check("pt_stall0", 32'(stall), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 4'd1, 4'd6, 16'h4321);
        @(negedge clk);
        check("pt_wb_data", 32'(wb_data), 32'h1234);
        check("pt_wb_reg", 32'(wb_reg_addr), 32'd3);
        check("pt_wb_we", 32'(wb_write_enable), 32'd1);
        check("pt_stall1", 32'(stall), 32'd0);
        next_cycle();
        @(negedge clk);
        check("pt2_wb_data", 32'(wb_data), 32'h4321);
        check("pt2_wb_reg", 32'(wb_reg_addr), 32'd6);
        check("pt2_wb_we", 32'(wb_write_enable), 32'd0);
        next_cycle();

        // Load, zero-wait memory
        drive(1'b1, 1'b0, 1'b1, 4'd5, 4'd7, 16'h1111);
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        check("ld_stall_n", 32'(stall), 32'd1);
        check("ld_req_n", 32'(mem_req), 32'd0);
        next_cycle();
        @(negedge clk);
        check("ld_stall_acc", 32'(stall), 32'd1);
        check("ld_req_acc", 32'(mem_req), 32'd1);
        check("ld_we_acc", 32'(mem_we), 32'd0);
        check("ld_addr_acc", 32'(mem_addr), 32'd5);
        check("ld_wbwe_acc", 32'(wb_write_enable), 32'd0);
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        check("ld_stall_resp", 32'(stall), 32'd0);
        check("ld_req_resp", 32'(mem_req), 32'd0);
        check("ld_wb_data", 32'(wb_data), 32'hBEEF);
        check("ld_wb_reg", 32'(wb_reg_addr), 32'd7);
        check("ld_wb_we", 32'(wb_write_enable), 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0000);
        @(negedge clk);
        check("ld_wb_we_pulse", 32'(wb_write_enable), 32'd0);
        check("ld_stall_after", 32'(stall), 32'd0);
        next_cycle();

        // Store, three ACCESS cycles
        drive(1'b0, 1'b1, 1'b0, 4'd9, 4'd2, 16'h00A5);
        @(negedge clk);
        check("st_stall_n", 32'(stall), 32'd1);
        check("st_wbwe_n", 32'(wb_write_enable), 32'd0);
        next_cycle();
        for (int i = 1; i <= 3; i++) begin
            mem_ready = (i == 3);
            @(negedge clk);
            check($sformatf("st_req_%0d", i), 32'(mem_req), 32'd1);
            check($sformatf("st_we_%0d", i), 32'(mem_we), 32'd1);
            check($sformatf("st_addr_%0d", i), 32'(mem_addr), 32'd9);
            check($sformatf("st_wdata_%0d", i), 32'(mem_wdata), 32'h00A5);
            check($sformatf("st_stall_%0d", i), 32'(stall), 32'd1);
            check($sformatf("st_wbwe_%0d", i), 32'(wb_write_enable), 32'd0);
            next_cycle();
        end
        mem_ready = 1'b0;
        @(negedge clk);
        check("st_req_resp", 32'(mem_req), 32'd0);
        check("st_stall_resp", 32'(stall), 32'd0);
        check("st_wbwe_resp", 32'(wb_write_enable), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0000);
        @(negedge clk);
        check("st_wbwe_after", 32'(wb_write_enable), 32'd0);
        next_cycle();

        // Load and store together: read wins
        drive(1'b1, 1'b1, 1'b1, 4'd2, 4'd4, 16'h7777);
        @(negedge clk);
        check("both_stall_n", 32'(stall), 32'd1);
        next_cycle();
        mem_ready = 1'b1;
        mem_rdata = 16'h0C0D;
        @(negedge clk);
        check("both_req", 32'(mem_req), 32'd1);
        check("both_we", 32'(mem_we), 32'd0);
        check("both_addr", 32'(mem_addr), 32'd2);
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        check("both_wb_data", 32'(wb_data), 32'h0C0D);
        check("both_wb_reg", 32'(wb_reg_addr), 32'd4);
        check("both_wb_we", 32'(wb_write_enable), 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0000);
        next_cycle();

        // Reset during ACCESS
        drive(1'b1, 1'b0, 1'b1, 4'd3, 4'd2, 16'h0000);
        next_cycle();
        @(negedge clk);
        check("rsta_req_acc", 32'(mem_req), 32'd1);
        next_cycle();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0000);
        next_cycle();
        @(negedge clk);
        check("rsta_req", 32'(mem_req), 32'd0);
        check("rsta_wbwe", 32'(wb_write_enable), 32'd0);
        check("rsta_stall", 32'(stall), 32'd0);
        check("rsta_addr", 32'(mem_addr), 32'd0);
        next_cycle();
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 4'd6, 4'd1, 16'h0000);
        mem_ready = 1'b1;
        mem_rdata = 16'h5A5A;
        next_cycle();
        @(negedge clk);
        check("rsta_ld_addr", 32'(mem_addr), 32'd6);
        check("rsta_ld_req", 32'(mem_req), 32'd1);
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        check("rsta_ld_wb_data", 32'(wb_data), 32'h5A5A);
        check("rsta_ld_wb_reg", 32'(wb_reg_addr), 32'd1);
        check("rsta_ld_wb_we", 32'(wb_write_enable), 32'd1);
        check("rsta_ld_err", 32'(mem_error), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0000);
        next_cycle();

`ifdef MEM_TIMEOUT_EN
        // Timeout after four ACCESS cycles without mem_ready
        drive(1'b1, 1'b0, 1'b1, 4'd8, 4'd5, 16'h0000);
        next_cycle();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("to_req_%0d", i), 32'(mem_req), 32'd1);
            check($sformatf("to_err_%0d", i), 32'(mem_error), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check("to_req_resp", 32'(mem_req), 32'd0);
        check("to_err_resp", 32'(mem_error), 32'd1);
        check("to_wbwe_resp", 32'(wb_write_enable), 32'd0);
        check("to_stall_resp", 32'(stall), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0000);
        @(negedge clk);
        check("to_err_sticky", 32'(mem_error), 32'd1);
        check("to_wbwe_after", 32'(wb_write_enable), 32'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        check("to_err_cleared", 32'(mem_error), 32'd0);
        next_cycle();
        reset = 1'b0;

        // mem_ready on the fourth ACCESS cycle completes normally
        drive(1'b1, 1'b0, 1'b1, 4'd8, 4'd5, 16'h0000);
        mem_rdata = 16'h9876;
        next_cycle();
        for (int i = 1; i <= 4; i++) begin
            mem_ready = (i == 4);
            @(negedge clk);
            check($sformatf("tok_req_%0d", i), 32'(mem_req), 32'd1);
            next_cycle();
        end
        mem_ready = 1'b0;
        @(negedge clk);
        check("tok_err", 32'(mem_error), 32'd0);
        check("tok_wb_we", 32'(wb_write_enable), 32'd1);
        check("tok_wb_data", 32'(wb_data), 32'h9876);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0000);
        next_cycle();
`else
        @(negedge clk);
        check("no_timeout_err", 32'(mem_error), 32'd0);
        next_cycle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
